// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared types, constants and GF(2^8) helpers for the AES datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MUL_09 = 2'd0,
    MUL_0B = 2'd1,
    MUL_0D = 2'd2,
    MUL_0E = 2'd3
  } mul_sel_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  // First row of the circulant inverse matrix; element [0] is the diagonal.
  localparam logic [3:0][1:0] INV_MIX_ROW0 = {MUL_09, MUL_0D, MUL_0B, MUL_0E};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic mul_sel_t inv_mix_sel(input logic [1:0] row, input logic [1:0] col);
    logic [1:0] idx;
    idx = col - row;
    return mul_sel_t'(INV_MIX_ROW0[idx]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inv_mixcolumn_module_if.sv
// ============================================================================
// inv_mixcolumn_module_if : start/done handshake and state/result columns
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface inv_mixcolumn_module_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] statew1;
  logic [31:0] statew2;
  logic [31:0] statew3;
  logic [31:0] statew4;
  logic [31:0] new_statew1;
  logic [31:0] new_statew2;
  logic [31:0] new_statew3;
  logic [31:0] new_statew4;

  modport master (
    output start, statew1, statew2, statew3, statew4,
    input  busy, done, new_statew1, new_statew2, new_statew3, new_statew4
  );

  modport slave (
    input  start, statew1, statew2, statew3, statew4,
    output busy, done, new_statew1, new_statew2, new_statew3, new_statew4
  );
endinterface

`default_nettype wire

// File: rtl/gf_mul_inv_const.sv
// ============================================================================
// gf_mul_inv_const : multiply a byte by 09/0B/0D/0E in GF(2^8)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gf_mul_inv_const
  import aes_pkg::*;
(
  input  logic [7:0] data_in,
  input  mul_sel_t   sel,
  output logic [7:0] data_out
);

  logic [7:0] x2;
  logic [7:0] x4;
  logic [7:0] x8;

  assign x2 = xtime(data_in);
  assign x4 = xtime(x2);
  assign x8 = xtime(x4);

  always_comb begin
    data_out = 8'h00;
    case (sel)
      MUL_09:  data_out = x8 ^ data_in;
      MUL_0B:  data_out = x8 ^ x2 ^ data_in;
      MUL_0D:  data_out = x8 ^ x4 ^ data_in;
      MUL_0E:  data_out = x8 ^ x4 ^ x2;
      default: data_out = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/inv_mixcolumn_module.sv
// ============================================================================
// inv_mixcolumn_module : AES InvMixColumns, one output byte per clock
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module inv_mixcolumn_module
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  inv_mixcolumn_module_if.slave bus
);

  localparam int            CNT_W = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_BYTES - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic [31:0]       snap [4];
  logic [31:0]       new_state [4];
  logic              busy;
  logic              done;

  logic [1:0]        row;
  logic [1:0]        col;
  logic [7:0]        term_in  [4];
  logic [7:0]        term_out [4];
  mul_sel_t          term_sel [4];
  logic [7:0]        byte_result;

  assign row = count[3:2];
  assign col = count[1:0];

  // Term k multiplies state byte (row k, column col) by M[row][k].
  for (genvar k = 0; k < 4; k++) begin : g_term
    assign term_in[k]  = snap[col][8*(3-k) +: 8];
    assign term_sel[k] = inv_mix_sel(row, 2'(k));

    gf_mul_inv_const u_mul (
      .data_in  (term_in[k]),
      .sel      (term_sel[k]),
      .data_out (term_out[k])
    );
  end

  assign byte_result = term_out[0] ^ term_out[1] ^ term_out[2] ^ term_out[3];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == LAST_COUNT) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < 4; i++) begin
        snap[i]      <= 32'h0;
        new_state[i] <= 32'h0;
      end
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          snap[0] <= bus.statew1;
          snap[1] <= bus.statew2;
          snap[2] <= bus.statew3;
          snap[3] <= bus.statew4;
          count   <= '0;
        end
        CALC: begin
          // Row 0 lives in the top byte of each column word.
          new_state[col][{~row, 3'b000} +: 8] <= byte_result;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.new_statew1 = new_state[0];
  assign bus.new_statew2 = new_state[1];
  assign bus.new_statew3 = new_state[2];
  assign bus.new_statew4 = new_state[3];

endmodule

`default_nettype wire

// File: tb/tb_inv_mixcolumn_module.sv
// ============================================================================
// tb_inv_mixcolumn_module : randomized self-checking bench for InvMixColumns
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_inv_mixcolumn_module;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_mixcolumn_module_if bus ();

  inv_mixcolumn_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain GF(2^8) multiplication and circulant matrices.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a ^= 8'h1B;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inverse) begin
      row0[0] = 8'h0E; row0[1] = 8'h0B; row0[2] = 8'h0D; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(row0[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  task automatic set_state(input logic [127:0] s);
    bus.statew1 = s[127:96];
    bus.statew2 = s[95:64];
    bus.statew3 = s[63:32];
    bus.statew4 = s[31:0];
  endtask

  function automatic logic [127:0] get_out();
    return {bus.new_statew1, bus.new_statew2, bus.new_statew3, bus.new_statew4};
  endfunction

  task automatic check_state(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_value({tag, ".col0"}, got[127:96], exp[127:96]);
    check_value({tag, ".col1"}, got[95:64],  exp[95:64]);
    check_value({tag, ".col2"}, got[63:32],  exp[63:32]);
    check_value({tag, ".col3"}, got[31:0],   exp[31:0]);
  endtask

  // One operation; lat = edges after acceptance until done is seen.
  task automatic run_op(input logic [127:0] st, input bit disturb,
                        output logic [127:0] res, output int lat, output int pulses,
                        output logic busy_first, output logic busy_end);
    res = 'x; lat = -1; pulses = 0;
    @(negedge clk);
    set_state(st);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    busy_first = bus.busy;
    if (disturb) set_state({4{32'hFFFF_FFFF}});
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (disturb && n == 5) bus.start = 1'b1;
      if (disturb && n == 6) bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          res = get_out();
        end
      end
      if (lat >= 0 && n >= lat + 2) break;
    end
    busy_end = bus.busy;
  endtask

  logic [127:0] res, st, orig, r1, r2;
  int           lat, pulses, d1, d2;
  logic         bf, be;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    set_state('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("reset.busy", 32'(bus.busy), 32'd0);
    check_value("reset.done", 32'(bus.done), 32'd0);
    check_state("reset.out", get_out(), '0);
    rst = 1'b0;

    // Known single column
    run_op({32'h8E4DA1BC, 96'h0}, 1'b0, res, lat, pulses, bf, be);
    check_state("col0", res, {32'hDB135345, 96'h0});
    check_value("col0.latency", 32'(lat), 32'd16);
    check_value("col0.pulses", 32'(pulses), 32'd1);

    // Full state with handshake timing
    run_op({32'h9FDC589D, 32'h01010101, 32'hC6C6C6C6, 32'hD5D5D7D6}, 1'b0, res, lat, pulses, bf, be);
    check_state("full", res, {32'hF20A225C, 32'h01010101, 32'hC6C6C6C6, 32'hD4D4D4D5});
    check_value("full.busy_after_accept", 32'(bf), 32'd1);
    check_value("full.busy_after_done", 32'(be), 32'd0);
    check_value("full.pulses", 32'(pulses), 32'd1);
    check_value("full.latency", 32'(lat), 32'd16);

    // Inputs change and start pulses after acceptance
    run_op({32'h4D7EBDF8, 96'h0}, 1'b1, res, lat, pulses, bf, be);
    check_state("snapshot", res, {32'h2D26314C, 96'h0});
    check_value("snapshot.pulses", 32'(pulses), 32'd1);
    check_value("snapshot.latency", 32'(lat), 32'd16);

    // Reset in the middle of an operation
    st = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    set_state(st);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_value("midreset.busy", 32'(bus.busy), 32'd0);
    check_value("midreset.done", 32'(bus.done), 32'd0);
    check_state("midreset.out", get_out(), '0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_value("midreset.no_done", 32'(pulses), 32'd0);
    st = {$urandom, $urandom, $urandom, $urandom};
    run_op(st, 1'b0, res, lat, pulses, bf, be);
    check_state("after_reset", res, mix(st, 1'b1));

    // Start held high: back-to-back operations
    st = {$urandom, $urandom, $urandom, $urandom};
    d1 = -1; d2 = -1; r1 = 'x; r2 = 'x;
    @(negedge clk);
    set_state(st);
    bus.start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = n; r1 = get_out();
        end else if (d2 < 0) begin
          d2 = n; r2 = get_out();
        end
      end
    end
    bus.start = 1'b0;
    check_value("held.first_done", 32'(d1), 32'd16);
    check_value("held.spacing", 32'(d2 - d1), 32'd18);
    check_state("held.r1", r1, mix(st, 1'b1));
    check_state("held.r2", r2, mix(st, 1'b1));
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check_value("held.drain", 32'(bus.busy), 32'd0);

    // Random round trip: forward MixColumns in the model, inverse in the DUT
    for (int v = 0; v < 1000; v++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      run_op(mix(orig, 1'b0), 1'b0, res, lat, pulses, bf, be);
      check_state("roundtrip", res, orig);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
